writeback_arbiter: RTL and testbench

Shares the single core writeback port between NUM_SOURCES message-unit producers (postoffice send results, receive unit, etc.) that each hold one pending writeback_arbiter_data_t entry. Each cycle at most one pending source is granted, round-robin, and acknowledged with a single-cycle pulse. The granted entry is captured into a one-entry output register that drives the core writeback interface under a valid/ready handshake. The block sits between the message-unit holding registers and the core writeback stage.

---
 rtl/xctcmsg_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 27 ++
 rtl/writeback_arbiter.sv | 69 ++++++
 tb/tb_writeback_arbiter.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/xctcmsg_pkg.sv
// xctcmsg_pkg: shared message-unit types and writeback source indices
package xctcmsg_pkg;

    typedef struct packed {
        logic [31:0] value;
        logic        passthrough;
    } writeback_arbiter_data_t;

    localparam int XCTCMSG_WB_SRC_POSTOFFICE = 0;
    localparam int XCTCMSG_WB_SRC_RECEIVE    = 1;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational rotate-priority encoder starting the scan at ptr
module rr_arbiter #(
    parameter int N     = 2,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] idx,
    output logic             any
);

    logic [PTR_W-1:0] j;

    // Scan from farthest to nearest so the entry closest to ptr wins last.
    always_comb begin
        idx = '0;
        j   = '0;
        any = |req;
        for (int k = N - 1; k >= 0; k--) begin
            j = PTR_W'((int'(ptr) + k) % N);
            if (req[j]) idx = j;
        end
        grant = any ? ({{(N-1){1'b0}}, 1'b1} << idx) : '0;
    end

endmodule

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: round-robin share of the core writeback port among
// message-unit producers, through a one-entry valid/ready output register.
module writeback_arbiter
    import xctcmsg_pkg::*;
#(
    parameter int NUM_SOURCES = 2,
    parameter int PTR_W       = $clog2(NUM_SOURCES)
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      flush,
    input  logic [NUM_SOURCES-1:0]                    src_valid,
    input  writeback_arbiter_data_t [NUM_SOURCES-1:0] src_data,
    output logic [NUM_SOURCES-1:0]                    src_acknowledge,
    output logic                                      wb_valid,
    input  logic                                      wb_ready,
    output writeback_arbiter_data_t                   wb_data,
    output logic [PTR_W-1:0]                          grant_idx
);

    logic                    out_valid;
    writeback_arbiter_data_t out_data;
    logic [PTR_W-1:0]        rr_ptr;
    logic [NUM_SOURCES-1:0]  rr_grant;
    logic [PTR_W-1:0]        rr_idx;
    logic                    rr_any;
    logic                    grant_en;

    rr_arbiter #(.N(NUM_SOURCES), .PTR_W(PTR_W)) u_rr (
        .req   (src_valid),
        .ptr   (rr_ptr),
        .grant (rr_grant),
        .idx   (rr_idx),
        .any   (rr_any)
    );

    // wb_ready only matters while the output register is occupied.
    always_comb begin
        grant_en        = !rst && !flush && (!out_valid || wb_ready) && rr_any;
        src_acknowledge = grant_en ? rr_grant : '0;
        grant_idx       = rr_idx;
        wb_valid        = out_valid;
        wb_data         = out_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            rr_ptr    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (grant_en) begin
            out_valid <= 1'b1;
            rr_ptr    <= (rr_idx == PTR_W'(NUM_SOURCES - 1)) ? '0 : rr_idx + 1'b1;
        end else if (wb_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (grant_en) out_data <= src_data[rr_idx];
    end

    for (genvar i = 0; i < NUM_SOURCES; i++) begin : g_hold
        a_hold: assert property (@(posedge clk) disable iff (rst)
            (src_valid[i] && !src_acknowledge[i] && !flush) |=> src_valid[i]);
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: directed vectors with a queue scoreboard for the
// writeback port, three sources to exercise non-power-of-2 pointer wrap.
module tb_writeback_arbiter;
    import xctcmsg_pkg::*;

    localparam int N     = 3;
    localparam int PTR_W = $clog2(N);

    logic                              clk = 1'b0;
    logic                              rst = 1'b1;
    logic                              flush = 1'b0;
    logic                              wb_ready = 1'b0;
    logic [N-1:0]                      src_valid = '0;
    writeback_arbiter_data_t [N-1:0]   src_data = '0;
    logic [N-1:0]                      src_acknowledge;
    logic                              wb_valid;
    writeback_arbiter_data_t           wb_data;
    logic [PTR_W-1:0]                  grant_idx;

    writeback_arbiter_data_t exp_q[$];
    int n_chk = 0;
    int n_fail = 0;
    int step_no = 0;

    writeback_arbiter #(.NUM_SOURCES(N)) dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .src_valid       (src_valid),
        .src_data        (src_data),
        .src_acknowledge (src_acknowledge),
        .wb_valid        (wb_valid),
        .wb_ready        (wb_ready),
        .wb_data         (wb_data),
        .grant_idx       (grant_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic int oh2i(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return 0;
    endfunction

    // Drive one cycle of inputs, check the combinational response mid-cycle.
    task automatic step(input logic [N-1:0] v, input logic r, input logic f,
                        input logic [N-1:0] ea, input logic ewv);
        step_no++;
        src_valid = v;
        wb_ready  = r;
        flush     = f;
        for (int i = 0; i < N; i++)
            src_data[i] = '{value: 32'(step_no * 16 + i), passthrough: 1'(i)};
        @(negedge clk);
        chk($sformatf("ack@%0d", step_no), 64'(src_acknowledge), 64'(ea));
        chk($sformatf("wb_valid@%0d", step_no), 64'(wb_valid), 64'(ewv));
        if (ea != '0) begin
            chk($sformatf("grant_idx@%0d", step_no), 64'(grant_idx), 64'(oh2i(ea)));
            exp_q.push_back(src_data[oh2i(ea)]);
        end
        if (ewv && !r && exp_q.size() > 0)
            chk($sformatf("wb_hold@%0d", step_no), 64'(wb_data), 64'(exp_q[0]));
        if (f && exp_q.size() > 0) void'(exp_q.pop_front());
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && wb_valid && wb_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL wb_unexpected: got %0h expected none", wb_data);
            end else begin
                chk("wb_data", 64'(wb_data), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        src_valid = '1;
        @(negedge clk);
        chk("rst_ack", 64'(src_acknowledge), 64'(0));
        chk("rst_wb_valid", 64'(wb_valid), 64'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        // single source
        step(3'b001, 1, 0, 3'b001, 0);
        step(3'b000, 1, 0, 3'b000, 1);
        step(3'b000, 1, 0, 3'b000, 0);
        // contention, back-to-back
        step(3'b111, 1, 0, 3'b010, 0);
        step(3'b111, 1, 0, 3'b100, 1);
        step(3'b111, 1, 0, 3'b001, 1);
        step(3'b111, 1, 0, 3'b010, 1);
        step(3'b111, 1, 0, 3'b100, 1);
        step(3'b111, 1, 0, 3'b001, 1);
        step(3'b110, 1, 0, 3'b010, 1);
        step(3'b100, 1, 0, 3'b100, 1);
        step(3'b000, 1, 0, 3'b000, 1);
        step(3'b000, 1, 0, 3'b000, 0);
        // backpressure
        step(3'b001, 1, 0, 3'b001, 0);
        for (int k = 0; k < 4; k++) step(3'b010, 0, 0, 3'b000, 1);
        step(3'b010, 1, 0, 3'b010, 1);
        step(3'b000, 1, 0, 3'b000, 1);
        step(3'b000, 1, 0, 3'b000, 0);
        // flush
        step(3'b001, 0, 0, 3'b001, 0);
        step(3'b001, 0, 1, 3'b000, 1);
        step(3'b001, 1, 0, 3'b001, 0);
        step(3'b000, 1, 0, 3'b000, 1);
        step(3'b000, 1, 0, 3'b000, 0);
        // wrap from pointer 2
        step(3'b010, 1, 0, 3'b010, 0);
        step(3'b000, 1, 0, 3'b000, 1);
        step(3'b001, 1, 0, 3'b001, 0);
        step(3'b000, 1, 0, 3'b000, 1);
        step(3'b011, 1, 0, 3'b010, 0);
        step(3'b001, 1, 0, 3'b001, 1);
        step(3'b000, 1, 0, 3'b000, 1);
        step(3'b000, 1, 0, 3'b000, 0);
        step(3'b100, 1, 0, 3'b100, 0);
        step(3'b011, 1, 0, 3'b001, 1);
        step(3'b010, 1, 0, 3'b010, 1);
        // asynchronous reset with an entry held and two requests pending
        src_valid = 3'b011;
        wb_ready  = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("midrst_ack", 64'(src_acknowledge), 64'(0));
        chk("midrst_wb_valid", 64'(wb_valid), 64'(0));
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        step(3'b011, 1, 0, 3'b001, 0);
        step(3'b010, 1, 0, 3'b010, 1);
        step(3'b000, 1, 0, 3'b000, 1);
        step(3'b000, 1, 0, 3'b000, 0);
        chk("queue_empty", 64'(exp_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
